// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare (feq/flt/fle) with RISC-V NaN and invalid semantics.
// The compare is resolved at issue; the stages carry result, flag and tag behind a valid/ready pipe.
module fcmp_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int FTZ    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_result,
    output logic                   out_nv,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef struct packed {
        logic             result;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;

    assign {sign_a, exp_a, man_a} = x1;
    assign {sign_b, exp_b, man_b} = x2;

    logic nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
    logic any_nan, any_snan, both_zero, mag_lt, mag_gt, is_eq, is_lt;
    res_t res_in;

    always_comb begin
        nan_a     = (&exp_a) && (|man_a);
        nan_b     = (&exp_b) && (|man_b);
        snan_a    = nan_a && !man_a[MAN_W-1];
        snan_b    = nan_b && !man_b[MAN_W-1];
        zero_a    = (exp_a == '0) && ((FTZ != 0) || (man_a == '0));
        zero_b    = (exp_b == '0) && ((FTZ != 0) || (man_b == '0));
        any_nan   = nan_a || nan_b;
        any_snan  = snan_a || snan_b;
        both_zero = zero_a && zero_b;
        mag_lt    = x1[W-2:0] < x2[W-2:0];
        mag_gt    = x2[W-2:0] < x1[W-2:0];
        is_eq     = (x1 == x2) || both_zero;
        // Negative operands order by reversed magnitude; signed zeros (and flushed denormals) tie.
        if (both_zero)
            is_lt = 1'b0;
        else if (sign_a != sign_b)
            is_lt = sign_a;
        else
            is_lt = sign_a ? mag_gt : mag_lt;

        res_in     = '0;
        res_in.tag = in_tag;
        case (op_e'(op))
            OP_FEQ: begin
                res_in.result = !any_nan && is_eq;
                res_in.nv     = any_snan;
            end
            OP_FLT: begin
                res_in.result = !any_nan && is_lt;
                res_in.nv     = any_nan;
            end
            OP_FLE: begin
                res_in.result = !any_nan && (is_lt || is_eq);
                res_in.nv     = any_nan;
            end
            default: ;
        endcase
    end

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES:0]   rdy;
    res_t [STAGES-1:0] data_q, data_d;

    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !vld_q[k] || rdy[k+1];
    end

    assign in_ready = rdy[0] && !rst;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rdy[0]) begin
            vld_d[0] = in_valid && in_ready;
            if (in_valid)
                data_d[0] = res_in;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1])
                    data_d[k] = data_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_q <= '0;
        else
            vld_q <= vld_d;
    end

    // Payload needs no reset: it is masked off whenever its stage is empty.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = out_valid && data_q[STAGES-1].result;
    assign out_nv     = out_valid && data_q[STAGES-1].nv;
    assign out_tag    = out_valid ? data_q[STAGES-1].tag : '0;

endmodule
